// File: rtl/serializer_arbiter_if.sv
// serializer_arbiter_if: groups the requester-side and serializer-side
// handshake signals of serializer_arbiter.
// The master modport is the arbiter. The slave modport is the environment,
// which holds the requesters and the serializer.
`timescale 1ns/1ps
interface serializer_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int LENGTH = 24
);
  logic [N_CH-1:0]         iv_req;
  logic [N_CH*LENGTH-1:0]  iv_din;
  logic [N_CH-1:0]         ov_ack;
  logic [LENGTH-1:0]       ov_ser_din;
  logic                    o_ser_din_valid;
  logic                    i_ser_ready;
  logic                    i_bit_strobe;
  logic [$clog2(N_CH)-1:0] ov_chan;
  logic                    o_busy;
  logic                    o_frame_done;

  modport master (
    input  iv_req, iv_din, i_ser_ready, i_bit_strobe,
    output ov_ack, ov_ser_din, o_ser_din_valid, ov_chan, o_busy, o_frame_done
  );

  modport slave (
    output iv_req, iv_din, i_ser_ready, i_bit_strobe,
    input  ov_ack, ov_ser_din, o_ser_din_valid, ov_chan, o_busy, o_frame_done
  );
endinterface

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: shares one bit-serializer among N_CH parallel-word
// requesters.
// - A requester is granted, and its word is captured.
// - The word is offered to the serializer with a valid/ready load.
// - The bit strobes are counted until LENGTH bits have gone out.
// - Only then does the arbiter move on to the next requester.
// Optional macro SERIALIZER_ARBITER_FIXED_PRIO_EN selects fixed priority,
// where the lowest index wins. The default is round-robin.
`timescale 1ns/1ps
module serializer_arbiter #(
  parameter int N_CH   = 4,
  parameter int LENGTH = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  serializer_arbiter_if.master bus
);
  localparam int CW   = $clog2(N_CH);
  localparam int IW   = CW + 1;
  localparam int CNTW = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [LENGTH-1:0] din_q, din_d;
  logic              valid_q, valid_d;
  logic [N_CH-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [CW-1:0]     sel_s;
  logic              found_s;
  logic [IW-1:0]     idx_s;

  // First requesting channel at or above ptr_q, wrapping modulo N_CH.
  // The loop runs from the farthest offset down, so the nearest requester is written last and wins.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx_s = {1'b0, ptr_q} + IW'(i);
      if (idx_s >= IW'(N_CH)) begin
        idx_s = idx_s - IW'(N_CH);
      end else begin
        idx_s = idx_s;
      end
      if (bus.iv_req[idx_s[CW-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[CW-1:0];
      end else begin
        found_s = found_s;
        sel_s   = sel_s;
      end
    end
  end

  // Next-state and next-output logic. Every output is a register loaded from its _d value.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    din_d   = din_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_LOAD;
          chan_d  = sel_s;
          din_d   = bus.iv_din[sel_s*LENGTH +: LENGTH];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.i_ser_ready) begin
          state_d       = ST_STREAM;
          ack_d[chan_q] = 1'b1;
          cnt_d         = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (bus.i_bit_strobe) begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(LENGTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef SERIALIZER_ARBITER_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (chan_q == CW'(N_CH - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = chan_q + CW'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_LOAD);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_STREAM);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers: synchronous reset, and a low i_en holds every register, including pending pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      chan_q  <= '0;
      din_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (i_en) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      din_q   <= din_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ov_ack          = ack_q;
  assign bus.ov_ser_din      = din_q;
  assign bus.o_ser_din_valid = valid_q;
  assign bus.ov_chan         = chan_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_frame_done    = done_q;
endmodule

// File: tb/tb_serializer_arbiter.sv
// tb_serializer_arbiter: directed checks of serializer_arbiter with
// N_CH=4 and LENGTH=24.
// Expected grant orders follow SERIALIZER_ARBITER_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_serializer_arbiter;
  localparam int N_CH   = 4;
  localparam int LENGTH = 24;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   dcount;
  logic [23:0] words [4];

  always #5 clk = ~clk;

  serializer_arbiter_if #(.N_CH(N_CH), .LENGTH(LENGTH)) bus ();

  serializer_arbiter #(.N_CH(N_CH), .LENGTH(LENGTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One complete frame: grant, load handshake, 24 strobes, done, back to idle.
  task automatic run_frame(input logic [3:0] req, input int exp_chan, input string tag);
    bus.iv_req = req;
    step();
    chk({tag, " chan"}, 32'(bus.ov_chan), 32'(exp_chan));
    chk({tag, " word"}, 32'(bus.ov_ser_din), 32'(words[exp_chan]));
    bus.i_ser_ready = 1'b1;
    step();
    bus.i_ser_ready = 1'b0;
    chk({tag, " ack"}, 32'(bus.ov_ack), 32'(1) << exp_chan);
    bus.i_bit_strobe = 1'b1;
    repeat (LENGTH) step();
    bus.i_bit_strobe = 1'b0;
    chk({tag, " done"}, 32'(bus.o_frame_done), 32'd1);
    step();
  endtask

  initial begin
    words[0] = 24'h111111;
    words[1] = 24'h222222;
    words[2] = 24'hA5A5A5;
    words[3] = 24'h333333;
    rst = 1'b1;
    en  = 1'b1;
    bus.iv_req       = 4'b0000;
    bus.iv_din       = {words[3], words[2], words[1], words[0]};
    bus.i_ser_ready  = 1'b0;
    bus.i_bit_strobe = 1'b0;

    // Reset held for two cycles: every output is zero.
    step();
    step();
    chk("rst ack",   32'(bus.ov_ack), 32'd0);
    chk("rst din",   32'(bus.ov_ser_din), 32'd0);
    chk("rst valid", 32'(bus.o_ser_din_valid), 32'd0);
    chk("rst chan",  32'(bus.ov_chan), 32'd0);
    chk("rst busy",  32'(bus.o_busy), 32'd0);
    chk("rst done",  32'(bus.o_frame_done), 32'd0);
    rst = 1'b0;

    // Single request on channel 2. Strobes stay high through IDLE and LOAD, and those strobes must be ignored.
    bus.iv_req       = 4'b0100;
    bus.i_bit_strobe = 1'b1;
    step();
    chk("t1 chan",  32'(bus.ov_chan), 32'd2);
    chk("t1 word",  32'(bus.ov_ser_din), 32'hA5A5A5);
    chk("t1 valid", 32'(bus.o_ser_din_valid), 32'd1);
    chk("t1 busy",  32'(bus.o_busy), 32'd1);
    bus.iv_req = 4'b0000;
    step();
    step();
    chk("t1 valid held", 32'(bus.o_ser_din_valid), 32'd1);
    chk("t1 no early ack", 32'(bus.ov_ack), 32'd0);
    bus.i_ser_ready = 1'b1;
    step();
    bus.i_ser_ready = 1'b0;
    chk("t1 ack", 32'(bus.ov_ack), 32'b0100);
    chk("t1 valid clr", 32'(bus.o_ser_din_valid), 32'd0);
    dcount = 0;
    for (int i = 0; i < LENGTH - 1; i++) begin
      step();
      if (i == 0) chk("t1 ack pulse", 32'(bus.ov_ack), 32'd0);
      if (bus.o_frame_done) dcount++;
    end
    chk("t1 no early done", 32'(dcount), 32'd0);
    step();
    chk("t1 done", 32'(bus.o_frame_done), 32'd1);
    chk("t1 busy in done", 32'(bus.o_busy), 32'd0);
    bus.i_bit_strobe = 1'b0;
    step();
    chk("t1 done once", 32'(bus.o_frame_done), 32'd0);
    chk("t1 word hold", 32'(bus.ov_ser_din), 32'hA5A5A5);

    // Round-robin over all four requesters, starting from pointer 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef SERIALIZER_ARBITER_FIXED_PRIO_EN
    run_frame(4'b1111, 0, "rr0");
    run_frame(4'b1111, 0, "rr1");
    run_frame(4'b1111, 0, "rr2");
    run_frame(4'b1111, 0, "rr3");
    run_frame(4'b1111, 0, "rr4");
`else
    run_frame(4'b1111, 0, "rr0");
    run_frame(4'b1111, 1, "rr1");
    run_frame(4'b1111, 2, "rr2");
    run_frame(4'b1111, 3, "rr3");
    run_frame(4'b1111, 0, "rr4");
`endif

    // Wrap and skip: requesters 0 and 3 only.
    rst = 1'b1;
    step();
    rst = 1'b0;
`ifdef SERIALIZER_ARBITER_FIXED_PRIO_EN
    run_frame(4'b1001, 0, "ws0");
    run_frame(4'b1001, 0, "ws1");
    run_frame(4'b1001, 0, "ws2");
`else
    run_frame(4'b1001, 0, "ws0");
    run_frame(4'b1001, 3, "ws1");
    run_frame(4'b1001, 0, "ws2");
`endif

    // Freeze: a pending ack is held and 23 strobes are counted. Then a disabled window with strobes present.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.iv_req = 4'b0010;
    step();
    bus.iv_req      = 4'b0000;
    bus.i_ser_ready = 1'b1;
    step();
    bus.i_ser_ready = 1'b0;
    chk("fz ack", 32'(bus.ov_ack), 32'b0010);
    en = 1'b0;
    bus.i_bit_strobe = 1'b1;
    step();
    step();
    chk("fz ack held", 32'(bus.ov_ack), 32'b0010);
    en = 1'b1;
    dcount = 0;
    for (int i = 0; i < LENGTH - 1; i++) begin
      step();
      if (bus.o_frame_done) dcount++;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.o_frame_done) dcount++;
    end
    chk("fz no done", 32'(dcount), 32'd0);
    chk("fz busy", 32'(bus.o_busy), 32'd1);
    en = 1'b1;
    step();
    chk("fz done", 32'(bus.o_frame_done), 32'd1);
    bus.i_bit_strobe = 1'b0;
    step();

    // Abort mid-STREAM after 10 strobes, once a frame has moved the pointer away from 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_frame(4'b0010, 1, "ab pre");
    bus.iv_req = 4'b0100;
    step();
    bus.iv_req      = 4'b0000;
    bus.i_ser_ready = 1'b1;
    step();
    bus.i_ser_ready  = 1'b0;
    bus.i_bit_strobe = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_bit_strobe = 1'b0;
    chk("ab busy",  32'(bus.o_busy), 32'd0);
    chk("ab valid", 32'(bus.o_ser_din_valid), 32'd0);
    chk("ab chan",  32'(bus.ov_chan), 32'd0);
    chk("ab din",   32'(bus.ov_ser_din), 32'd0);

    // Abort mid-LOAD while ready is high: no ack may follow.
    bus.iv_req = 4'b1000;
    step();
    chk("abl valid", 32'(bus.o_ser_din_valid), 32'd1);
    bus.iv_req      = 4'b0000;
    bus.i_ser_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_ser_ready = 1'b0;
    chk("abl ack0", 32'(bus.ov_ack), 32'd0);
    step();
    chk("abl ack1", 32'(bus.ov_ack), 32'd0);
    chk("abl idle", 32'(bus.o_busy), 32'd0);

    // After the aborts, the next frame starts at channel 0.
    bus.iv_req = 4'b1111;
    step();
    chk("ab restart chan", 32'(bus.ov_chan), 32'd0);
    bus.iv_req = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
